ex_stage_fwd: RTL and testbench

Parametrised execute stage with an integrated EX/MEM pipeline register. It resolves operand hazards by forwarding from EX/MEM and MEM/WB. It detects load-use hazards and stalls for them, and it runs an iterative multiply that holds the front end until the product is ready. It sits between the ID/EX register and the memory stage. It also supplies the stall signal that freezes PC, IF/ID and ID/EX.

---
 rtl/ex_stage_fwd.sv | 198 +++++++++++++++++++
 tb/tb_ex_stage_fwd.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_stage_fwd.sv
// Execute stage with EX/MEM register: operand forwarding, load-use stall and
// an iterative shift-add multiplier that freezes the front end while busy.
module ex_stage_fwd #(
    parameter int DW = 16,
    parameter int RW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          valid_i,
    input  logic          flush_i,
    input  logic [3:0]    aluop_i,
    input  logic [DW-1:0] src1_i,
    input  logic [DW-1:0] src2_i,
    input  logic [RW-1:0] regsrc1_i,
    input  logic [RW-1:0] regsrc2_i,
    input  logic [RW-1:0] regdst_i,
    input  logic          regwrite_i,
    input  logic          memread_i,
    input  logic [RW-1:0] wbregdst_i,
    input  logic          wbregwrite_i,
    input  logic [DW-1:0] wbregdata_i,
    output logic          stall_o,
    output logic          exmem_valid_o,
    output logic [DW-1:0] exmem_res_o,
    output logic [RW-1:0] exmem_regdst_o,
    output logic          exmem_regwrite_o,
    output logic          exmem_memread_o
);
    localparam int SW = $clog2(DW);
    localparam int CW = $clog2(DW + 1);
    localparam logic [RW-1:0] NOREG    = '1;
    localparam logic [3:0]    OP_MUL   = 4'd9;
    localparam logic [CW-1:0] CNT_INIT = CW'(DW);
    localparam logic [CW-1:0] CNT_LAST = CW'(1);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [DW-1:0] mcand_q, mcand_d, mplier_q, mplier_d, acc_q, acc_d;
    logic [RW-1:0] mdst_q, mdst_d;
    logic          mwr_q, mwr_d;
    logic          exmem_valid_q, exmem_valid_d;
    logic [DW-1:0] exmem_res_q, exmem_res_d;
    logic [RW-1:0] exmem_regdst_q, exmem_regdst_d;
    logic          exmem_regwrite_q, exmem_regwrite_d;
    logic          exmem_memread_q, exmem_memread_d;

    logic [DW-1:0] op_a, op_b, alu_res, acc_step;
    logic [SW-1:0] shamt;
    logic          load_use, start;

    // EX/MEM only forwards ALU results; a load's value is not known until MEM/WB.
    function automatic logic [DW-1:0] fwd(
        input logic [RW-1:0] rs, input logic [DW-1:0] raw,
        input logic ex_ok, input logic [RW-1:0] ex_dst, input logic [DW-1:0] ex_res,
        input logic wb_wr, input logic [RW-1:0] wb_dst, input logic [DW-1:0] wb_data);
        if (rs == NOREG)                  return raw;
        else if (ex_ok && ex_dst == rs)   return ex_res;
        else if (wb_wr && wb_dst == rs)   return wb_data;
        else                              return raw;
    endfunction

    always_comb begin
        op_a = fwd(regsrc1_i, src1_i,
                   exmem_valid_q && exmem_regwrite_q && !exmem_memread_q,
                   exmem_regdst_q, exmem_res_q, wbregwrite_i, wbregdst_i, wbregdata_i);
        op_b = fwd(regsrc2_i, src2_i,
                   exmem_valid_q && exmem_regwrite_q && !exmem_memread_q,
                   exmem_regdst_q, exmem_res_q, wbregwrite_i, wbregdst_i, wbregdata_i);
        shamt = op_b[SW-1:0];
        load_use = valid_i && exmem_valid_q && exmem_memread_q && exmem_regwrite_q &&
                   ((regsrc1_i != NOREG && regsrc1_i == exmem_regdst_q) ||
                    (regsrc2_i != NOREG && regsrc2_i == exmem_regdst_q));
        start    = valid_i && (aluop_i == OP_MUL) && !load_use && !flush_i;
        acc_step = acc_q + (mplier_q[0] ? mcand_q : '0);
    end

    always_comb begin
        alu_res = '0;
        case (aluop_i)
            4'd0:    alu_res = op_a + op_b;
            4'd1:    alu_res = op_a - op_b;
            4'd2:    alu_res = op_a & op_b;
            4'd3:    alu_res = op_a | op_b;
            4'd4:    alu_res = op_a ^ op_b;
            4'd5:    alu_res = op_a << shamt;
            4'd6:    alu_res = op_a >> shamt;
            4'd7:    alu_res = $signed(op_a) >>> shamt;
            4'd8:    alu_res = {{(DW-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
            4'd10:   alu_res = op_b;
            default: alu_res = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q          <= IDLE;
            cnt_q            <= '0;
            mcand_q          <= '0;
            mplier_q         <= '0;
            acc_q            <= '0;
            mdst_q           <= '0;
            mwr_q            <= 1'b0;
            exmem_valid_q    <= 1'b0;
            exmem_res_q      <= '0;
            exmem_regdst_q   <= '0;
            exmem_regwrite_q <= 1'b0;
            exmem_memread_q  <= 1'b0;
        end else begin
            state_q          <= state_d;
            cnt_q            <= cnt_d;
            mcand_q          <= mcand_d;
            mplier_q         <= mplier_d;
            acc_q            <= acc_d;
            mdst_q           <= mdst_d;
            mwr_q            <= mwr_d;
            exmem_valid_q    <= exmem_valid_d;
            exmem_res_q      <= exmem_res_d;
            exmem_regdst_q   <= exmem_regdst_d;
            exmem_regwrite_q <= exmem_regwrite_d;
            exmem_memread_q  <= exmem_memread_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        mdst_d   = mdst_q;
        mwr_d    = mwr_q;
        case (state_q)
            IDLE: if (start) begin
                state_d  = BUSY;
                cnt_d    = CNT_INIT;
                mcand_d  = op_a;
                mplier_d = op_b;
                acc_d    = '0;
                mdst_d   = regdst_i;
                mwr_d    = regwrite_i;
            end
            BUSY: if (flush_i) begin
                state_d = IDLE;
                cnt_d   = '0;
            end else begin
                acc_d    = acc_step;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q - CNT_LAST;
                if (cnt_q == CNT_LAST) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Anything not explicitly producing a result is a bubble with all fields zero.
    always_comb begin
        stall_o          = 1'b0;
        exmem_valid_d    = 1'b0;
        exmem_res_d      = '0;
        exmem_regdst_d   = '0;
        exmem_regwrite_d = 1'b0;
        exmem_memread_d  = 1'b0;
        case (state_q)
            IDLE: if (!flush_i) begin
                if (load_use || start) begin
                    stall_o = 1'b1;
                end else if (valid_i) begin
                    exmem_valid_d    = 1'b1;
                    exmem_res_d      = alu_res;
                    exmem_regdst_d   = regdst_i;
                    exmem_regwrite_d = regwrite_i;
                    exmem_memread_d  = memread_i;
                end
            end
            BUSY: if (!flush_i) begin
                if (cnt_q == CNT_LAST) begin
                    exmem_valid_d    = 1'b1;
                    exmem_res_d      = acc_step;
                    exmem_regdst_d   = mdst_q;
                    exmem_regwrite_d = mwr_q;
                end else begin
                    stall_o = 1'b1;
                end
            end
            default: stall_o = 1'b0;
        endcase
        if (rst) stall_o = 1'b0;
    end

    assign exmem_valid_o    = exmem_valid_q;
    assign exmem_res_o      = exmem_res_q;
    assign exmem_regdst_o   = exmem_regdst_q;
    assign exmem_regwrite_o = exmem_regwrite_q;
    assign exmem_memread_o  = exmem_memread_q;
endmodule

// File: tb/tb_ex_stage_fwd.sv
// Bench for ex_stage_fwd: directed hazard/multiply/flush/reset cases, then a
// random instruction stream checked against sequential ISA semantics.
module tb_ex_stage_fwd;
  localparam int DW = 16;
  localparam int RW = 4;
  localparam int W  = DW + RW + 2;
  localparam logic [RW-1:0] NOREG = '1;
  localparam int N_RND = 300;

  logic          clk = 1'b0;
  logic          rst, valid_i, flush_i, regwrite_i, memread_i, wbregwrite_i;
  logic [3:0]    aluop_i;
  logic [DW-1:0] src1_i, src2_i, wbregdata_i;
  logic [RW-1:0] regsrc1_i, regsrc2_i, regdst_i, wbregdst_i;
  logic          stall_o, exmem_valid_o, exmem_regwrite_o, exmem_memread_o;
  logic [DW-1:0] exmem_res_o;
  logic [RW-1:0] exmem_regdst_o;

  always #5 clk = ~clk;

  ex_stage_fwd #(.DW(DW), .RW(RW)) dut (
    .clk(clk), .rst(rst), .valid_i(valid_i), .flush_i(flush_i), .aluop_i(aluop_i),
    .src1_i(src1_i), .src2_i(src2_i), .regsrc1_i(regsrc1_i), .regsrc2_i(regsrc2_i),
    .regdst_i(regdst_i), .regwrite_i(regwrite_i), .memread_i(memread_i),
    .wbregdst_i(wbregdst_i), .wbregwrite_i(wbregwrite_i), .wbregdata_i(wbregdata_i),
    .stall_o(stall_o), .exmem_valid_o(exmem_valid_o), .exmem_res_o(exmem_res_o),
    .exmem_regdst_o(exmem_regdst_o), .exmem_regwrite_o(exmem_regwrite_o),
    .exmem_memread_o(exmem_memread_o)
  );

  int n_total = 0;
  int n_bad   = 0;
  logic [W-1:0] exp_q[$];

  typedef struct packed {
    logic          v;
    logic [3:0]    op;
    logic [DW-1:0] i1, i2;
    logic [RW-1:0] r1, r2, dst;
    logic          wr, mr;
  } instr_t;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp_v);
    n_total++;
    if (got !== exp_v) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp_v);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [3:0] op, input logic [DW-1:0] s1,
                       input logic [DW-1:0] s2, input logic [RW-1:0] r1,
                       input logic [RW-1:0] r2, input logic [RW-1:0] dst,
                       input logic wr, input logic mr);
    valid_i = v; aluop_i = op; src1_i = s1; src2_i = s2;
    regsrc1_i = r1; regsrc2_i = r2; regdst_i = dst; regwrite_i = wr; memread_i = mr;
  endtask

  task automatic drive_wb(input logic wr, input logic [RW-1:0] dst, input logic [DW-1:0] d);
    wbregwrite_i = wr; wbregdst_i = dst; wbregdata_i = d;
  endtask

  task automatic idle_in();
    drive(1'b0, 4'd0, '0, '0, NOREG, NOREG, '0, 1'b0, 1'b0);
    drive_wb(1'b0, '0, '0);
    flush_i = 1'b0;
  endtask

  // Reference semantics written as plain integer arithmetic.
  function automatic logic [DW-1:0] ref_alu(input logic [3:0] op, input logic [DW-1:0] a,
                                            input logic [DW-1:0] b);
    int ua, ub, sa, sb, sh, r;
    longint p;
    ua = int'(a); ub = int'(b);
    sa = a[DW-1] ? ua - 65536 : ua;
    sb = b[DW-1] ? ub - 65536 : ub;
    sh = ub % DW;
    p  = longint'(ua) * longint'(ub);
    case (op)
      4'd0:    r = ua + ub;
      4'd1:    r = ua - ub;
      4'd2:    r = ua & ub;
      4'd3:    r = ua | ub;
      4'd4:    r = ua ^ ub;
      4'd5:    r = ua << sh;
      4'd6:    r = ua >> sh;
      4'd7:    r = sa >>> sh;
      4'd8:    r = (sa < sb) ? 1 : 0;
      4'd9:    r = int'(p % 65536);
      4'd10:   r = ub;
      default: r = 0;
    endcase
    return r[DW-1:0];
  endfunction

  function automatic logic [DW-1:0] mem_f(input logic [DW-1:0] addr);
    return {addr[7:0], addr[15:8]} ^ 16'h3C5A;
  endfunction

  function automatic logic [RW-1:0] pick_reg();
    int t;
    t = $urandom_range(0, 4);
    return (t == 4) ? NOREG : RW'(t);
  endfunction

  function automatic instr_t gen();
    instr_t x;
    x.v   = ($urandom_range(0, 9) != 0);
    x.op  = 4'($urandom_range(0, 15));
    x.i1  = DW'($urandom_range(0, 65535));
    x.i2  = DW'($urandom_range(0, 65535));
    x.r1  = pick_reg();
    x.r2  = pick_reg();
    x.dst = RW'($urandom_range(0, 3));
    if ($urandom_range(0, 5) == 0) begin
      x.op = 4'd0; x.mr = 1'b1; x.wr = 1'b1;
    end else begin
      x.mr = 1'b0; x.wr = ($urandom_range(0, 7) != 0);
    end
    return x;
  endfunction

  task automatic run_mul(input string tag, input logic [DW-1:0] a, input logic [DW-1:0] b,
                         input logic [DW-1:0] prod);
    int stalls, edges;
    logic got_valid;
    drive(1'b1, 4'd9, a, b, NOREG, NOREG, 4'd5, 1'b1, 1'b0);
    drive_wb(1'b0, '0, '0);
    stalls = 0; edges = 0; got_valid = 1'b0;
    while (!got_valid && edges < 40) begin
      #1;
      if (stall_o) stalls++;
      step();
      edges++;
      got_valid = exmem_valid_o;
    end
    check({tag, "_stalls"}, 32'(stalls), 32'(DW));
    check({tag, "_edges"}, 32'(edges), 32'(DW + 1));
    check({tag, "_valid"}, 32'(got_valid), 32'd1);
    check({tag, "_res"}, 32'(exmem_res_o), 32'(prod));
    check({tag, "_dst"}, 32'(exmem_regdst_o), 32'd5);
    idle_in();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] rf[16], arch[16];
    instr_t cur;
    logic have_cur, acc_last, hung, saw;
    logic mw_wr, pv, pwr, pmr;
    logic [RW-1:0] mw_dst, pdst;
    logic [DW-1:0] mw_data, pres, a, b, res;
    logic [W-1:0] e;
    int issued, cyc, stall_run;

    // Reset holds outputs at zero and suppresses stall even with a MUL presented.
    rst = 1'b1;
    idle_in();
    drive(1'b1, 4'd9, 16'd3, 16'd4, NOREG, NOREG, 4'd1, 1'b1, 1'b0);
    #1 check("rst_stall", 32'(stall_o), 32'd0);
    step();
    check("rst_valid", 32'(exmem_valid_o), 32'd0);
    check("rst_res", 32'(exmem_res_o), 32'd0);
    step();
    rst = 1'b0;
    idle_in();
    step();

    // EX/MEM forward beats MEM/WB forward
    drive(1'b1, 4'd0, 16'd2, 16'd3, NOREG, NOREG, 4'd1, 1'b1, 1'b0);
    step();
    check("fwd_first", 32'(exmem_res_o), 32'd5);
    drive(1'b1, 4'd0, 16'd0, 16'd0, 4'd1, 4'd1, 4'd2, 1'b1, 1'b0);
    drive_wb(1'b1, 4'd1, 16'd9);
    #1 check("fwd_nostall", 32'(stall_o), 32'd0);
    step();
    check("fwd_prio_res", 32'(exmem_res_o), 32'd10);
    check("fwd_prio_dst", 32'(exmem_regdst_o), 32'd2);

    // NOREG operand is never forwarded
    drive(1'b1, 4'd0, 16'd100, 16'd0, NOREG, NOREG, 4'd15, 1'b1, 1'b0);
    drive_wb(1'b0, '0, '0);
    step();
    drive(1'b1, 4'd0, 16'd3, 16'd4, 4'd15, NOREG, 4'd2, 1'b1, 1'b0);
    drive_wb(1'b1, 4'd15, 16'd50);
    step();
    check("noreg_res", 32'(exmem_res_o), 32'd7);

    // Load-use: one bubble, then operand from MEM/WB
    drive(1'b1, 4'd0, 16'h0020, 16'd0, NOREG, NOREG, 4'd3, 1'b1, 1'b1);
    drive_wb(1'b0, '0, '0);
    step();
    check("ld_memread", 32'(exmem_memread_o), 32'd1);
    drive(1'b1, 4'd1, 16'd0, 16'd1, 4'd3, NOREG, 4'd4, 1'b1, 1'b0);
    #1 check("lu_stall", 32'(stall_o), 32'd1);
    step();
    check("lu_bubble", 32'(exmem_valid_o), 32'd0);
    check("lu_bubble_wr", 32'(exmem_regwrite_o), 32'd0);
    drive_wb(1'b1, 4'd3, 16'h0010);
    #1 check("lu_release", 32'(stall_o), 32'd0);
    step();
    check("lu_res", 32'(exmem_res_o), 32'h000F);
    check("lu_valid", 32'(exmem_valid_o), 32'd1);
    idle_in();
    step();

    run_mul("mul_7x9", 16'd7, 16'd9, 16'd63);
    step();
    run_mul("mul_big", 16'h1234, 16'h0100, 16'h3400);
    step();

    // Flush in IDLE kills the instruction
    drive(1'b1, 4'd0, 16'd5, 16'd5, NOREG, NOREG, 4'd1, 1'b1, 1'b0);
    flush_i = 1'b1;
    #1 check("flush_idle_stall", 32'(stall_o), 32'd0);
    step();
    check("flush_idle_valid", 32'(exmem_valid_o), 32'd0);
    idle_in();

    // Flush in BUSY cycle 5 aborts the multiply
    drive(1'b1, 4'd9, 16'd7, 16'd9, NOREG, NOREG, 4'd5, 1'b1, 1'b0);
    step();
    repeat (4) step();
    flush_i = 1'b1;
    step();
    idle_in();
    #1 check("flush_busy_stall", 32'(stall_o), 32'd0);
    check("flush_busy_valid", 32'(exmem_valid_o), 32'd0);
    saw = 1'b0;
    repeat (20) begin
      step();
      if (exmem_valid_o) saw = 1'b1;
    end
    check("flush_no_result", 32'(saw), 32'd0);
    drive(1'b1, 4'd0, 16'd1, 16'd1, NOREG, NOREG, 4'd6, 1'b1, 1'b0);
    #1 check("flush_after_stall", 32'(stall_o), 32'd0);
    step();
    check("flush_after_res", 32'(exmem_res_o), 32'd2);
    idle_in();

    // Reset in BUSY cycle 3
    drive(1'b1, 4'd9, 16'd3, 16'd5, NOREG, NOREG, 4'd5, 1'b1, 1'b0);
    step(); step(); step();
    rst = 1'b1;
    #1 check("rstmid_stall", 32'(stall_o), 32'd0);
    step();
    check("rstmid_valid", 32'(exmem_valid_o), 32'd0);
    check("rstmid_res", 32'(exmem_res_o), 32'd0);
    check("rstmid_dst", 32'(exmem_regdst_o), 32'd0);
    check("rstmid_wr", 32'(exmem_regwrite_o), 32'd0);
    check("rstmid_mr", 32'(exmem_memread_o), 32'd0);
    rst = 1'b0;
    drive(1'b1, 4'd0, 16'd2, 16'd2, NOREG, NOREG, 4'd7, 1'b1, 1'b0);
    #1 check("rstmid_add_stall", 32'(stall_o), 32'd0);
    step();
    check("rstmid_add_res", 32'(exmem_res_o), 32'd4);
    check("rstmid_add_valid", 32'(exmem_valid_o), 32'd1);
    idle_in();
    saw = 1'b0;
    repeat (20) begin
      step();
      if (exmem_valid_o) saw = 1'b1;
    end
    check("rstmid_no_result", 32'(saw), 32'd0);

    // Random program: bench plays IF/ID, MEM, WB and the register file.
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int i = 0; i < 16; i++) begin
      rf[i] = DW'($urandom_range(0, 65535));
      arch[i] = rf[i];
    end
    mw_wr = 1'b0; mw_dst = '0; mw_data = '0;
    pv = 1'b0; pwr = 1'b0; pmr = 1'b0; pdst = '0; pres = '0;
    have_cur = 1'b0; acc_last = 1'b0; hung = 1'b0;
    issued = 0; cyc = 0; stall_run = 0;
    cur = '0;
    while ((issued < N_RND || have_cur || acc_last) && cyc < 20000) begin
      cyc++;
      if (mw_wr) rf[mw_dst] = mw_data;
      mw_wr   = pv && pwr;
      mw_dst  = pdst;
      mw_data = pmr ? mem_f(pres) : pres;
      check("rnd_valid", 32'(exmem_valid_o), 32'(acc_last));
      if (exmem_valid_o && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("rnd_res", 32'(exmem_res_o), 32'(e[W-1:RW+2]));
        check("rnd_dst", 32'(exmem_regdst_o), 32'(e[RW+1:2]));
        check("rnd_wr", 32'(exmem_regwrite_o), 32'(e[1]));
        check("rnd_mr", 32'(exmem_memread_o), 32'(e[0]));
      end
      pv = exmem_valid_o; pres = exmem_res_o; pdst = exmem_regdst_o;
      pwr = exmem_regwrite_o; pmr = exmem_memread_o;
      if (!have_cur && issued < N_RND) begin
        cur = gen();
        have_cur = 1'b1;
        issued++;
      end
      if (have_cur)
        drive(cur.v, cur.op, (cur.r1 == NOREG) ? cur.i1 : rf[cur.r1],
              (cur.r2 == NOREG) ? cur.i2 : rf[cur.r2], cur.r1, cur.r2, cur.dst, cur.wr, cur.mr);
      else
        drive(1'b0, 4'd0, '0, '0, NOREG, NOREG, '0, 1'b0, 1'b0);
      drive_wb(mw_wr, mw_dst, mw_data);
      @(negedge clk);
      if (have_cur && !stall_o) begin
        if (cur.v) begin
          a = (cur.r1 == NOREG) ? cur.i1 : arch[cur.r1];
          b = (cur.r2 == NOREG) ? cur.i2 : arch[cur.r2];
          res = ref_alu(cur.op, a, b);
          if (cur.wr) arch[cur.dst] = cur.mr ? mem_f(res) : res;
          exp_q.push_back({res, cur.dst, cur.wr, cur.mr});
        end
        acc_last = cur.v;
        have_cur = 1'b0;
        stall_run = 0;
      end else begin
        acc_last = 1'b0;
        if (have_cur) stall_run++;
      end
      if (stall_run > DW + 2) begin
        hung = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
    end
    check("rnd_hang", 32'(hung), 32'd0);
    check("rnd_q_empty", 32'(exp_q.size()), 32'd0);
    check("rnd_all_issued", 32'(issued), 32'(N_RND));

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
